uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the UART link; it produces the line that the receive side deserialises. It accepts bytes from a parallel producer over a valid/ready handshake and buffers one byte in a holding register, so back-to-back frames leave the line with no idle gap. Each byte is serialised LSB-first as start bit, 8 data bits, optional parity and 1–2 stop bits. Each bit is held for a programmable number of clock cycles.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range ≥1.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled on handshake.
- valid  input  1  producer has a byte on data_in.
- ready  output  1  holding register empty; handshake when valid && ready at a rising edge.
- tx  output  1  serial line, idle high; registered output.
- busy  output  1  frame in progress or holding register full.

## Operation
- Reset values: tx=1, busy=0, holding register empty, state IDLE, baud counter 0. ready is 0 while rst=1 and 1 from the first cycle after reset.
- ready = !hold_full, combinational from a register; it does not depend on valid.
- Handshake: on a handshake edge, data_in is written into the holding register and hold_full is set.
- Loading: at any edge where the engine is IDLE and hold_full=1, or the engine finishes the last stop bit and hold_full=1:
  - shift register ← holding register;
  - hold_full is cleared;
  - state → START.
- Simultaneous handshake and load at the same edge: the load takes the old holding contents and the new byte is written into the holding register. hold_full stays 1.
- States:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right at each bit boundary; 8 bits.
  - PARITY: tx = ^byte for even, ~^byte for odd. Skipped when PARITY=0.
  - STOP: tx=1 for STOP_BITS bits.
  - Exit from STOP goes to START if hold_full=1, otherwise to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT), minimum 1. Resets to 0 on every state entry. A bit boundary occurs when the counter equals CLKS_PER_BIT-1; the counter then wraps to 0. When CLKS_PER_BIT=1, every cycle is a boundary.
- Bit counter: 3 bits for data, 1 bit for stop. Resets on state entry.
- busy = (state != IDLE) || hold_full.
- Reset mid-frame: the frame is aborted immediately, tx returns to 1 and the holding contents are discarded.
- The transmitter never stalls mid-frame; the producer is throttled only through ready.

## Timing
- Latency: with the engine idle and the buffer empty, a handshake at edge N loads at N+1. tx goes low after edge N+2 (one cycle to the holding register, one to the engine).
- Frame length is (1 + 8 + (PARITY!=0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Each bit is exactly CLKS_PER_BIT cycles, with no jitter.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop cycle, with zero idle cycles.
- Throughput: at most one handshake per frame in steady state. ready reasserts the cycle after each load.
- tx is glitch-free because it is driven directly from a flop.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the PARITY_NONE/EVEN/ODD constants;
  - the default CLKS_PER_BIT, shared with the receiver.
- One sub-module, uart_baud_cnt: a parameterised counter with clear and tick outputs. The receiver can reuse it later.
- The holding register, shift register and FSM all sit in uart_tx.

## Test plan
- Reset, then idle for 20 cycles -> tx=1, busy=0, ready=1 throughout; ready=0 while rst is high.
- CLKS_PER_BIT=4, PARITY=0, send 0xA5 -> tx holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles (40 cycles total). busy deasserts on the cycle after the last stop cycle.
- PARITY=1 with 0xA5 gives parity bit 0; PARITY=2 with 0xA5 gives 1; PARITY=1 with 0x07 gives 1. STOP_BITS=2 adds 4 extra high cycles.
- Back-to-back: valid held high with 0x55 then 0xAA -> second handshake occurs one cycle after the first load. ready stays low until the second load. The second start bit immediately follows the first stop bit with no idle cycle.
- CLKS_PER_BIT=1 with 0xFF -> tx is low for 1 cycle, then high for 9 cycles.
- Assert rst during data bit 3 of 0x3C while a second byte is held -> tx=1 and ready=0 during reset; after reset release no frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART types and constants (transmitter and receiver)
// Rev 1.0
// ============================================================================
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 4;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// uart_baud_cnt : bit-period counter, ticks on the last cycle of each bit
// Rev 1.0
// ============================================================================
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt_q;
    logic [c_cnt_w-1:0] w_cnt_d;

    assign o_tick = (r_cnt_q == c_last);

    always_comb begin
        w_cnt_d = r_cnt_q + c_cnt_w'(1);
        if (i_clr || o_tick) begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : UART serialiser with a one-byte holding register for gapless frames
// Rev 1.0
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam logic c_last_stop = 1'(STOP_BITS - 1);

    uart_state_e r_state_q, w_state_d;
    logic [7:0]  r_hold_q, w_hold_d;
    logic [7:0]  r_shift_q, w_shift_d;
    logic [2:0]  r_bit_cnt_q, w_bit_cnt_d;
    logic        r_hold_full_q, w_hold_full_d;
    logic        r_par_q, w_par_d;
    logic        r_tx_q, w_tx_d;
    logic        r_busy_q, w_busy_d;
    logic        w_hs, w_load, w_tick, w_last_stop, w_baud_clr;

    assign ready = !rst && !r_hold_full_q;
    assign w_hs  = valid && ready;
    assign tx    = r_tx_q;
    assign busy  = r_busy_q;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_baud_clr),
        .o_tick(w_tick)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_shift_d   = r_shift_q;
        w_par_d     = r_par_q;
        w_bit_cnt_d = r_bit_cnt_q;
        w_last_stop = (r_state_q == ST_STOP) && w_tick && (r_bit_cnt_q[0] == c_last_stop);
        w_load      = r_hold_full_q && ((r_state_q == ST_IDLE) || w_last_stop);

        case (r_state_q)
            ST_IDLE: ;
            ST_START: if (w_tick) w_state_d = ST_DATA;
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_d   = {1'b0, r_shift_q[7:1]};
                    w_bit_cnt_d = r_bit_cnt_q + 3'd1;
                    if (r_bit_cnt_q == 3'd7) begin
                        w_state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: if (w_tick) w_state_d = ST_STOP;
            ST_STOP: begin
                if (w_tick) begin
                    w_bit_cnt_d = r_bit_cnt_q + 3'd1;
                    if (w_last_stop) w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        if (w_state_d != r_state_q) w_bit_cnt_d = '0;

        // Load wins over the normal STOP exit so the next start bit follows with no gap.
        if (w_load) begin
            w_state_d   = ST_START;
            w_shift_d   = r_hold_q;
            w_par_d     = parity_bit(r_hold_q, PARITY);
            w_bit_cnt_d = '0;
        end

        w_hold_d      = w_hs ? data_in : r_hold_q;
        w_hold_full_d = w_hs || (r_hold_full_q && !w_load);
        w_baud_clr    = (r_state_q == ST_IDLE) || (w_state_d != r_state_q);

        case (r_state_q)
            ST_START:  w_tx_d = 1'b0;
            ST_DATA:   w_tx_d = r_shift_q[0];
            ST_PARITY: w_tx_d = r_par_q;
            default:   w_tx_d = 1'b1;
        endcase
        w_busy_d = (r_state_q != ST_IDLE) || r_hold_full_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_hold_q      <= '0;
            r_hold_full_q <= 1'b0;
            r_shift_q     <= '0;
            r_bit_cnt_q   <= '0;
            r_par_q       <= 1'b0;
            r_tx_q        <= 1'b1;
            r_busy_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_hold_q      <= w_hold_d;
            r_hold_full_q <= w_hold_full_d;
            r_shift_q     <= w_shift_d;
            r_bit_cnt_q   <= w_bit_cnt_d;
            r_par_q       <= w_par_d;
            r_tx_q        <= w_tx_d;
            r_busy_q      <= w_busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : directed checks of uart_tx framing, parity, stop bits and reset
// Rev 1.0
// ============================================================================
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din [4];
    logic [3:0] vld;
    wire  [3:0] rdy_v;
    wire  [3:0] tx_v;
    wire  [3:0] bsy_v;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .valid(vld[0]),
        .ready(rdy_v[0]), .tx(tx_v[0]), .busy(bsy_v[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .valid(vld[1]),
        .ready(rdy_v[1]), .tx(tx_v[1]), .busy(bsy_v[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(din[2]), .valid(vld[2]),
        .ready(rdy_v[2]), .tx(tx_v[2]), .busy(bsy_v[2]));
    uart_tx #(.CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) u_dut3 (
        .clk(clk), .rst(rst), .data_in(din[3]), .valid(vld[3]),
        .ready(rdy_v[3]), .tx(tx_v[3]), .busy(bsy_v[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // bits is the frame in time order, LSB first: {stops, parity, data, start}.
    task automatic send_frame(input int idx, input logic [7:0] b, input logic [23:0] bits,
                              input int nbits, input int cpb, input string tag);
        din[idx] = b;
        vld[idx] = 1'b1;
        @(posedge clk); #1;
        vld[idx] = 1'b0;
        chk({tag, "_rdy_after_hs"}, 32'(rdy_v[idx]), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_rdy_after_load"}, 32'(rdy_v[idx]), 32'd1);
        chk({tag, "_tx_before_start"}, 32'(tx_v[idx]), 32'd1);
        for (int k = 0; k < nbits * cpb; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_tx_cyc%0d", tag, k), 32'(tx_v[idx]), 32'(bits[k / cpb]));
        end
        chk({tag, "_busy_last_stop"}, 32'(bsy_v[idx]), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, 32'(bsy_v[idx]), 32'd0);
        chk({tag, "_tx_after"}, 32'(tx_v[idx]), 32'd1);
    endtask

    initial begin
        logic [23:0] b2b_bits;
        rst = 1'b1;
        vld = 4'h0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy_v), 32'h0);
        chk("rst_tx", 32'(tx_v), 32'hF);
        chk("rst_busy", 32'(bsy_v), 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(rdy_v), 32'hF);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk($sformatf("idle_tx%0d", c), 32'(tx_v), 32'hF);
            chk($sformatf("idle_busy%0d", c), 32'(bsy_v), 32'h0);
            chk($sformatf("idle_rdy%0d", c), 32'(rdy_v), 32'hF);
        end

        send_frame(0, 8'hA5, 24'b1_10100101_0,     10, 4, "np_a5");
        send_frame(1, 8'hA5, 24'b1_1_0_10100101_0, 12, 4, "even2_a5");
        send_frame(2, 8'hA5, 24'b1_1_10100101_0,   11, 4, "odd_a5");
        send_frame(1, 8'h07, 24'b1_1_1_00000111_0, 12, 4, "even2_07");
        send_frame(3, 8'hFF, 24'b1_11111111_0,     10, 1, "cpb1_ff");

        b2b_bits = 24'b1_10101010_0_1_01010101_0;
        din[0] = 8'h55;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        chk("b2b_rdy_after_hs1", 32'(rdy_v[0]), 32'd0);
        din[0] = 8'hAA;
        @(posedge clk); #1;
        chk("b2b_rdy_after_load1", 32'(rdy_v[0]), 32'd1);
        @(posedge clk); #1;
        vld[0] = 1'b0;
        chk("b2b_rdy_after_hs2", 32'(rdy_v[0]), 32'd0);
        for (int k = 0; k < 80; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            chk($sformatf("b2b_tx_cyc%0d", k), 32'(tx_v[0]), 32'(b2b_bits[k / 4]));
            if (k == 38) chk("b2b_rdy_before_load2", 32'(rdy_v[0]), 32'd0);
            if (k == 39) chk("b2b_rdy_after_load2", 32'(rdy_v[0]), 32'd1);
        end
        @(posedge clk); #1;
        chk("b2b_busy_after", 32'(bsy_v[0]), 32'd0);

        din[0] = 8'h3C;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        din[0] = 8'h81;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_tx_bit1", 32'(tx_v[0]), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("mid_tx_bit3", 32'(tx_v[0]), 32'd1);
        chk("mid_rdy_held", 32'(rdy_v[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rdy_in_rst", 32'(rdy_v[0]), 32'd0);
        @(posedge clk); #1;
        chk("mid_tx_in_rst", 32'(tx_v[0]), 32'd1);
        chk("mid_busy_in_rst", 32'(bsy_v[0]), 32'd0);
        chk("mid_rdy_in_rst2", 32'(rdy_v[0]), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_tx%0d", c), 32'(tx_v[0]), 32'd1);
            chk($sformatf("post_rst_busy%0d", c), 32'(bsy_v[0]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
